// File: rtl/logic_seq32.sv
// Slice-serial bitwise logic unit (AND/OR/XOR/NOR), one SLICE_W-bit slice per clock, LSB first.
// Optional result==0 flag built only when LOGIC_SEQ_ZERO_FLAG_EN is defined.
module logic_seq32 #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  acc_d;
    logic [DATA_W-1:0]  result_q;
    logic               busy_q;
    logic               done_q;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_res;

    // Operands shift right one slice per RUN cycle, so the current slice is always at the bottom.
    assign slice_a = a_q[SLICE_W-1:0];
    assign slice_b = b_q[SLICE_W-1:0];

    always_comb begin
        slice_res = '0;
        case (op_q)
            2'b00:   slice_res = slice_a & slice_b;
            2'b01:   slice_res = slice_a | slice_b;
            2'b10:   slice_res = slice_a ^ slice_b;
            default: slice_res = ~(slice_a | slice_b);
        endcase
    end

    // Accumulator fills from the top; after NSLICE shifts slice k sits at [k*SLICE_W +: SLICE_W].
    generate
        if (NSLICE > 1) begin : g_acc_shift
            assign acc_d = {slice_res, acc_q[DATA_W-1:SLICE_W]};
        end else begin : g_acc_single
            assign acc_d = slice_res;
        end
    endgenerate

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic zero_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> SLICE_W;
                    b_q   <= b_q >> SLICE_W;
                    acc_q <= acc_d;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                        zero_q   <= (acc_d == '0);
`endif
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign zero   = zero_q;
`else
    assign zero   = 1'b0;
`endif

endmodule

// File: tb/tb_logic_seq32.sv
// Directed, table-driven bench for logic_seq32: vector table plus back-to-back,
// ignored-start, zero-flag and mid-run reset sequences.
module tb_logic_seq32;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks;
    int errors;

    logic_seq32 #(.DATA_W(32), .SLICE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic exp_zero(input logic [31:0] r);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        return (r == 32'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Pulse start for one cycle, then count sampled edges until done (bounded).
    task automatic do_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output int busy_cycles);
        bit seen;
        seen = 0;
        lat = 0;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = va;
        b = vb;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                lat = c;
            end
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        int gap;
        logic [31:0] r1;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;

        vecs[0] = '{2'b01, 32'h0F0F0000, 32'h00FF00F0, 32'h0FFF00F0};
        vecs[1] = '{2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
        vecs[2] = '{2'b10, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
        vecs[3] = '{2'b11, 32'h12345678, 32'h0F0F0F0F, 32'hE0C0A080};
        vecs[4] = '{2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
        vecs[5] = '{2'b00, 32'h80000001, 32'hFFFFFFFF, 32'h80000001};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_zero", {31'b0, zero}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 32'd9);
            chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd8);
            chk($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, exp_zero(vecs[i].exp)});
            $display("vec%0d op=%0d a=%h b=%h result=%h latency=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, result, lat);
        end

        // Back-to-back: AND then XOR with start held high through DONE.
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        a = 32'hFFFF0000;
        b = 32'h0F0F0F0F;
        dcount = 0;
        gap = 0;
        r1 = '0;
        for (int c = 1; c <= 40 && dcount < 2; c++) begin
            @(negedge clk);
            if (dcount == 1) gap++;
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    r1 = result;
                    op = 2'b10;
                    a = 32'hAAAAAAAA;
                    b = 32'hFFFFFFFF;
                end
            end else if (dcount == 1 && gap == 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_first_result", r1, 32'h0F0F0000);
        chk("b2b_second_result", result, 32'h55555555);
        chk("b2b_done_gap", gap, 32'd9);
        $display("b2b first=%h second=%h gap=%0d", r1, result, gap);

        // Start pulsed and operands changed mid-RUN must be ignored.
        @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        a = 32'h0;
        b = 32'h0;
        dcount = 0;
        bc = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) begin
                start = 1'b1;
                op = 2'b00;
                a = 32'hFFFF1234;
                b = 32'h00005678;
            end
            if (c == 4) start = 1'b0;
            if (busy) bc++;
            if (done) dcount++;
        end
        chk("ignored_start_done_count", dcount, 32'd1);
        chk("ignored_start_result", result, 32'hFFFFFFFF);
        chk("ignored_start_busy_cycles", bc, 32'd8);
        $display("ignored-start result=%h dones=%0d busy_cycles=%0d", result, dcount, bc);

        // Zero flag sequence.
        do_op(2'b11, 32'hFFFFFFFF, 32'h0, lat, bc);
        chk("zf_nor_result", result, 32'h0);
        chk("zf_nor_zero", {31'b0, zero}, {31'b0, exp_zero(32'h0)});
        $display("zero-flag NOR result=%h zero=%0d", result, zero);
        do_op(2'b01, 32'h1, 32'h0, lat, bc);
        chk("zf_or_result", result, 32'h1);
        chk("zf_or_zero", {31'b0, zero}, 32'h0);
        $display("zero-flag OR result=%h zero=%0d", result, zero);

        // Reset mid-RUN: outputs clear immediately, no done after release.
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        a = 32'hFFFFFFFF;
        b = 32'h0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_zero", {31'b0, zero}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        bc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bc++;
        end
        chk("midrst_no_done", dcount, 32'd0);
        chk("midrst_no_busy", bc, 32'd0);
        chk("midrst_result_after", result, 32'h0);
        $display("mid-run reset dones=%0d busy_cycles=%0d result=%h", dcount, bc, result);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
